// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and duration helpers for the intersection controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6
  } phase_e;

  // ARM issues the timer start; BLANK masks a stale timeFinished; RUN waits for it.
  typedef enum logic [1:0] {
    SUB_ARM   = 2'd0,
    SUB_BLANK = 2'd1,
    SUB_RUN   = 2'd2
  } sub_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int unsigned DUR_MAX = 127;

  // A zero duration would make the timer finish immediately; treat it as one second.
  function automatic logic [6:0] clamp_dur(input int unsigned d);
    if (d == 0) begin
      return 7'd1;
    end
    return 7'(d);
  endfunction

endpackage

// Elaboration-time guard: a duration that does not fit the 7-bit timer field stops the build.
`define TRAFFIC_DUR_CHECK(lbl, val) \
  if ((val) > traffic_pkg::DUR_MAX) begin : lbl \
    $error("traffic duration parameter exceeds 127 seconds"); \
  end

// File: rtl/ped_request_sync.sv
// Pedestrian button conditioning: 2-flop synchroniser, rising-edge detect, sticky pending flag.
// Latency: pending sets 3 edges after pedReq rises; clear takes effect on the next edge.
// Backpressure: none; a held button yields one request, an edge coinciding with clear is absorbed.
module ped_request_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic pedReq,
  input  logic clear,
  output logic pending
);

  logic sync1;
  logic sync2;
  logic sync2_prev;
  logic rise;

  assign rise = sync2 & ~sync2_prev;

  // Synchronise the raw button, remember the previous level, and latch a request until cleared.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_prev <= 1'b0;
      pending    <= 1'b0;
    end else begin
      sync1      <= pedReq;
      sync2      <= sync1;
      sync2_prev <= sync2;
      if (clear) begin
        pending <= 1'b0;
      end else if (rise) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic light phase FSM with optional pedestrian walk, driving the seconds timer.
// Latency: accepted timeFinished -> new phase, lamps and startCounting pulse one edge later.
// Backpressure: timeFinished ignored in ARM and first RUN cycle; pedestrian requests stay latched.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned T_GREEN  = 20,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_WALK   = 10
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       timeFinished,
  input  logic       pedReq,
  output logic       startCounting,
  output logic [6:0] secondsToCount,
  output logic [2:0] nsLights,
  output logic [2:0] ewLights,
  output logic       walk,
  output logic [2:0] phase
);

  `TRAFFIC_DUR_CHECK(g_chk_green,  T_GREEN)
  `TRAFFIC_DUR_CHECK(g_chk_yellow, T_YELLOW)
  `TRAFFIC_DUR_CHECK(g_chk_allred, T_ALLRED)
  `TRAFFIC_DUR_CHECK(g_chk_walk,   T_WALK)

  localparam logic [6:0] D_GREEN  = clamp_dur(T_GREEN);
  localparam logic [6:0] D_YELLOW = clamp_dur(T_YELLOW);
  localparam logic [6:0] D_ALLRED = clamp_dur(T_ALLRED);
  localparam logic [6:0] D_WALK   = clamp_dur(T_WALK);

  phase_e     phase_q;
  phase_e     phase_d;
  sub_e       sub_q;
  sub_e       sub_d;
  logic       started_q;
  logic       ped_pending;
  logic       ped_clear;
  logic       start_d;
  logic [6:0] secs_d;
  logic [6:0] dur_d;
  logic [2:0] ns_d;
  logic [2:0] ew_d;
  logic       walk_d;

  // The request is consumed when the walk phase is armed.
  assign ped_clear = (phase_q == PED_WALK) && (sub_q == SUB_ARM);
  assign phase     = phase_q;

  ped_request_sync u_ped (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .pedReq  (pedReq),
    .clear   (ped_clear),
    .pending (ped_pending)
  );

  // Next phase/sub-state, plus lamp, walk and duration decode of that next state.
  always_comb begin
    phase_d = phase_q;
    sub_d   = sub_q;
    dur_d   = D_ALLRED;
    ns_d    = LAMP_R;
    ew_d    = LAMP_R;
    walk_d  = 1'b0;

    if (!started_q) begin
      // The reset state is ALLRED_B ARM; its start pulse is issued on the first edge out of reset.
      phase_d = ALLRED_B;
      sub_d   = SUB_ARM;
    end else begin
      case (sub_q)
        SUB_ARM:   sub_d = SUB_BLANK;
        SUB_BLANK: sub_d = SUB_RUN;
        SUB_RUN: begin
          if (timeFinished) begin
            sub_d = SUB_ARM;
            case (phase_q)
              NS_GREEN:  phase_d = NS_YELLOW;
              NS_YELLOW: phase_d = ALLRED_A;
              ALLRED_A:  phase_d = EW_GREEN;
              EW_GREEN:  phase_d = EW_YELLOW;
              EW_YELLOW: phase_d = ALLRED_B;
              ALLRED_B:  phase_d = ped_pending ? PED_WALK : NS_GREEN;
              default:   phase_d = NS_GREEN;
            endcase
          end
        end
        default: sub_d = SUB_ARM;
      endcase
    end

    case (phase_d)
      NS_GREEN:  begin dur_d = D_GREEN;  ns_d = LAMP_G; end
      NS_YELLOW: begin dur_d = D_YELLOW; ns_d = LAMP_Y; end
      ALLRED_A:  begin dur_d = D_ALLRED; end
      EW_GREEN:  begin dur_d = D_GREEN;  ew_d = LAMP_G; end
      EW_YELLOW: begin dur_d = D_YELLOW; ew_d = LAMP_Y; end
      ALLRED_B:  begin dur_d = D_ALLRED; end
      PED_WALK:  begin dur_d = D_WALK;   walk_d = 1'b1; end
      default:   begin dur_d = D_ALLRED; end
    endcase

    // A start pulse accompanies every entry into ARM; the duration holds until the next one.
    start_d = (sub_d == SUB_ARM);
    secs_d  = start_d ? dur_d : secondsToCount;
  end

  // State register and registered outputs, all moving on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase_q        <= ALLRED_B;
      sub_q          <= SUB_ARM;
      started_q      <= 1'b0;
      startCounting  <= 1'b0;
      secondsToCount <= 7'd0;
      nsLights       <= LAMP_R;
      ewLights       <= LAMP_R;
      walk           <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      sub_q          <= sub_d;
      started_q      <= 1'b1;
      startCounting  <= start_d;
      secondsToCount <= secs_d;
      nsLights       <= ns_d;
      ewLights       <= ew_d;
      walk           <= walk_d;
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer: timer model, behavioural phase model, scenarios.
// Latency: model predicts outputs per edge; compare runs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_traffic_phase_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       timeFinished = 1'b0;
  logic       pedReq = 1'b0;
  logic       startCounting;
  logic [6:0] secondsToCount;
  logic [2:0] nsLights;
  logic [2:0] ewLights;
  logic       walk;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;

  traffic_phase_sequencer #(
    .T_GREEN (20),
    .T_YELLOW(3),
    .T_ALLRED(1),
    .T_WALK  (10)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .timeFinished  (timeFinished),
    .pedReq        (pedReq),
    .startCounting (startCounting),
    .secondsToCount(secondsToCount),
    .nsLights      (nsLights),
    .ewLights      (ewLights),
    .walk          (walk),
    .phase         (phase)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timer model: finishes dly cycles after a start pulse and holds until the next start.
  int tcnt = 0;
  int dly = 5;
  bit stuck = 1'b0;
  always @(negedge CLK) begin
    if (stuck) begin
      timeFinished = 1'b1;
    end else if (startCounting) begin
      tcnt = 0;
      timeFinished = 1'b0;
    end else begin
      if (tcnt < 1000) tcnt++;
      timeFinished = (tcnt >= dly);
    end
  end

  // Phase rules expressed as plain tables.
  function automatic int succ(input int p, input bit pend);
    if (p == 5) return pend ? 6 : 0;
    if (p == 6) return 0;
    return p + 1;
  endfunction

  function automatic int dur_of(input int p);
    case (p)
      0, 3:    return 20;
      1, 4:    return 3;
      6:       return 10;
      default: return 1;
    endcase
  endfunction

  function automatic int ns_of(input int p);
    if (p == 0) return 1;
    if (p == 1) return 2;
    return 4;
  endfunction

  function automatic int ew_of(input int p);
    if (p == 3) return 1;
    if (p == 4) return 2;
    return 4;
  endfunction

  // Behavioural model state: phase, cycles since phase start, pending request, sampled button history.
  bit m_started = 0;
  int m_phase = 5;
  int m_age = 0;
  bit m_pend = 0;
  bit h1 = 0, h2 = 0, h3 = 0;
  int m_secs = 0;
  bit m_start = 0;

  // Observation counters used by the scenario checks.
  int cyc = 0;
  int ped_entries = 0;
  int walk_cycles = 0;

  initial begin
    bit clr;
    bit rise;
    forever begin
      @(posedge CLK);
      cyc++;
      if (!RST_N) begin
        m_started = 0; m_phase = 5; m_age = 0; m_pend = 0;
        h1 = 0; h2 = 0; h3 = 0; m_secs = 0; m_start = 0;
      end else begin
        clr  = m_started && (m_phase == 6) && (m_age == 0);
        rise = h2 && !h3;
        if (!m_started) begin
          m_started = 1; m_phase = 5; m_age = 0;
        end else if (m_age >= 2 && timeFinished) begin
          m_phase = succ(m_phase, m_pend);
          m_age = 0;
        end else begin
          m_age++;
        end
        m_pend = clr ? 1'b0 : (rise ? 1'b1 : m_pend);
        h3 = h2; h2 = h1; h1 = pedReq;
        m_start = (m_age == 0);
        if (m_start) m_secs = dur_of(m_phase);
      end
      #1;
      check("phase", int'(phase), m_phase);
      check("startCounting", int'(startCounting), int'(m_start));
      check("secondsToCount", int'(secondsToCount), m_secs);
      check("nsLights", int'(nsLights), m_started ? ns_of(m_phase) : 4);
      check("ewLights", int'(ewLights), m_started ? ew_of(m_phase) : 4);
      check("walk", int'(walk), int'(m_started && m_phase == 6));
      if (RST_N && startCounting && phase == 3'd6) ped_entries++;
      if (walk) walk_cycles++;
    end
  end

  // Wait for the next start pulse (bounded); reports the phase, duration and walk lamp seen then.
  task automatic wait_start(output int ph, output int secs, output int w);
    bit got;
    got = 0;
    ph = -1; secs = -1; w = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge CLK);
      #2;
      if (startCounting) begin
        got = 1;
        ph = int'(phase);
        secs = int'(secondsToCount);
        w = int'(walk);
      end
    end
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL start_timeout got=none want=pulse at %0t", $time);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ph, secs, w, c0, prev_ph, p0, w0;
    int seq[7];
    seq = '{0, 1, 2, 3, 4, 5, 0};

    // Reset values.
    repeat (3) @(negedge CLK);
    check("rst_phase", int'(phase), 5);
    check("rst_ns", int'(nsLights), 3'b100);
    check("rst_ew", int'(ewLights), 3'b100);
    check("rst_start", int'(startCounting), 0);
    check("rst_secs", int'(secondsToCount), 0);
    check("rst_walk", int'(walk), 0);

    // First edge after release arms ALLRED_B, then the fixed rotation.
    RST_N = 1'b1;
    @(posedge CLK); #2;
    check("edge1_start", int'(startCounting), 1);
    check("edge1_secs", int'(secondsToCount), 1);
    check("edge1_ns", int'(nsLights), 3'b100);
    check("edge1_ew", int'(ewLights), 3'b100);
    check("edge1_phase", int'(phase), 5);
    for (int i = 0; i < 7; i++) begin
      wait_start(ph, secs, w);
      check("seq_phase", ph, seq[i]);
    end

    // Two idle rotations: no walk phase.
    p0 = ped_entries; w0 = walk_cycles;
    for (int i = 0; i < 12; i++) wait_start(ph, secs, w);
    check("idle_ped_entries", ped_entries - p0, 0);
    check("idle_walk_cycles", walk_cycles - w0, 0);

    // Short press during EW_GREEN -> walk after ALLRED_B.
    ph = -1;
    for (int i = 0; i < 8 && ph != 3; i++) wait_start(ph, secs, w);
    @(negedge CLK) pedReq = 1'b1;
    repeat (4) @(negedge CLK);
    pedReq = 1'b0;
    wait_start(ph, secs, w); check("press_p4", ph, 4);
    wait_start(ph, secs, w); check("press_p5", ph, 5);
    wait_start(ph, secs, w);
    check("press_walk_phase", ph, 6);
    check("press_walk_secs", secs, 10);
    check("press_walk_lamp", w, 1);
    wait_start(ph, secs, w);
    check("after_walk_phase", ph, 0);
    check("after_walk_lamp", w, 0);

    // Held button: one request only.
    p0 = ped_entries;
    @(negedge CLK) pedReq = 1'b1;
    repeat (200) @(negedge CLK);
    pedReq = 1'b0;
    for (int i = 0; i < 15; i++) wait_start(ph, secs, w);
    check("held_ped_entries", ped_entries - p0, 1);

    // Random button activity and timer durations, checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 24) == 0) pedReq = ~pedReq;
      if (i % 40 == 0) dly = $urandom_range(1, 7);
    end
    pedReq = 1'b0;
    dly = 5;

    // timeFinished stuck high: one phase every 3 cycles.
    @(negedge CLK) stuck = 1'b1;
    wait_start(ph, secs, w);
    for (int i = 0; i < 4; i++) begin
      c0 = cyc; prev_ph = ph;
      wait_start(ph, secs, w);
      check("stuck_interval", cyc - c0, 3);
      check("stuck_advanced", int'(ph != prev_ph), 1);
    end
    @(negedge CLK) stuck = 1'b0;

    // Reset during EW_GREEN RUN.
    ph = -1;
    for (int i = 0; i < 10 && ph != 3; i++) wait_start(ph, secs, w);
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("midrst_phase", int'(phase), 5);
    check("midrst_ns", int'(nsLights), 3'b100);
    check("midrst_ew", int'(ewLights), 3'b100);
    check("midrst_walk", int'(walk), 0);
    check("midrst_start", int'(startCounting), 0);
    check("midrst_secs", int'(secondsToCount), 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #2;
    check("restart_start", int'(startCounting), 1);
    check("restart_secs", int'(secondsToCount), 1);
    check("restart_phase", int'(phase), 5);
    wait_start(ph, secs, w); check("restart_p0", ph, 0);
    check("restart_p0_secs", secs, 20);
    wait_start(ph, secs, w); check("restart_p1", ph, 1);

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Intersection phase controller, directly upstream of the seconds timer. It steps a two-road traffic light through green, yellow and all-red phases, plus an optional pedestrian walk phase. For each phase it loads the timer with a duration via `startCounting`/`secondsToCount` and advances on the timer's `timeFinished`. A pedestrian push-button request is synchronised, edge-detected and latched until it is serviced.

## Interface
- `T_GREEN`, 20, green duration in seconds (7-bit, 1..127)
- `T_YELLOW`, 3, yellow duration in seconds
- `T_ALLRED`, 1, all-red clearance duration in seconds
- `T_WALK`, 10, pedestrian walk duration in seconds
- `CLK`  in  1  system clock (10 kHz, shared with the timer)
- `RST_N`  in  1  reset, asynchronous assert, active-low
- `timeFinished`  in  1  from timer; high while elapsed seconds equal the loaded duration
- `pedReq`  in  1  raw pedestrian button, asynchronous, active-high
- `startCounting`  out  1  one-cycle pulse to the timer; restarts its count
- `secondsToCount`  out  7  duration for the timer; stable from the start pulse until the next start pulse
- `nsLights`  out  3  north–south lamps, one-hot {R,Y,G}
- `ewLights`  out  3  east–west lamps, one-hot {R,Y,G}
- `walk`  out  1  pedestrian walk lamp
- `phase`  out  3  current phase code, for debug and the display stage

## Operation
- Phases, with duration and lamps:
  - NS_GREEN: `T_GREEN`; ns=G, ew=R
  - NS_YELLOW: `T_YELLOW`; ns=Y, ew=R
  - ALLRED_A: `T_ALLRED`; both R
  - EW_GREEN: `T_GREEN`; ns=R, ew=G
  - EW_YELLOW: `T_YELLOW`; ns=R, ew=Y
  - ALLRED_B: `T_ALLRED`; both R
  - PED_WALK: `T_WALK`; both R, `walk`=1
- Transitions occur only on an accepted `timeFinished`.
  - Order: NS_GREEN→NS_YELLOW→ALLRED_A→EW_GREEN→EW_YELLOW→ALLRED_B.
  - From ALLRED_B: go to PED_WALK if a pedestrian request is pending, else to NS_GREEN.
  - PED_WALK→NS_GREEN.
- Each phase has two sub-states:
  - ARM: one cycle; drives `startCounting`=1 and `secondsToCount`=phase duration.
  - RUN: waits for the timer.
- Blanking: `timeFinished` is ignored in the ARM cycle and the first RUN cycle, because the timer's flag from the previous duration may still be high. It is accepted from the second RUN cycle onward.
- Pedestrian path: `pedReq` passes through a 2-flop synchroniser, then rising-edge detect, then a sticky pending flag.
  - The flag is cleared in the ARM cycle of PED_WALK.
  - An edge in that same cycle is absorbed; it does not re-set the flag.
  - A held button produces one request only.
- Lamps and `walk` are registered, decoded from the next state, and change on the same edge as the phase.
- Duration parameters of 0 are clamped to 1. Values above 127 are a synthesis-time error (check in the package).

## Timing
- Reset values while `RST_N` is low:
  - `phase`=ALLRED_B, sub-state ARM
  - `nsLights`=`ewLights`=R (3'b100), `walk`=0
  - `startCounting`=0, `secondsToCount`=0, pending flag=0, synchroniser flops=0
- First rising edge after `RST_N` deassertion: `startCounting`=1 and `secondsToCount`=`T_ALLRED` (ALLRED_B ARM).
- Phase advance: accepted `timeFinished` at edge k gives the new phase, lamps and `startCounting`=1 at edge k+1.
  - One phase therefore spans the timer period plus 2 cycles.
- Pedestrian request latency: the pending flag sets 3 edges after `pedReq` rises.
  - A request becomes visible to the ALLRED_B decision only if the flag is set at or before the accepting edge.
- Reset mid-phase: the block returns immediately to the reset values, regardless of timer state.
- `timeFinished` held high continuously advances exactly one phase per 3 cycles: ARM, blank, accept.

## Structure
- Shared package `traffic_pkg` (include file) holds:
  - phase codes: NS_GREEN=0 … PED_WALK=6
  - lamp encodings: R=3'b100, Y=3'b010, G=3'b001
  - duration range-check macro
- Sub-module `ped_request_sync` contains the synchroniser, edge detect and pending flag. Ports: `CLK`, `RST_N`, `pedReq`, `clear`, `pending`.
- The FSM and phase-to-lamp/duration decode live in the top module.

## Test plan
The bench uses a behavioural timer model that raises `timeFinished` 5 cycles after `startCounting` and holds it until the next start.
- Reset release → edge 1: `startCounting`=1, `secondsToCount`=1, both lamps 3'b100; then `phase` sequence 5→0→1→2→3→4→5→0.
- No `pedReq` for two full cycles → PED_WALK is never entered; `walk` is always 0.
- `pedReq` pulsed high for 4 cycles during EW_GREEN → after ALLRED_B, `phase`=6, `walk`=1, `secondsToCount`=10; then NS_GREEN with `walk`=0.
- `pedReq` held high for 200 cycles → exactly one PED_WALK occurs.
- `timeFinished` stuck at 1 → `startCounting` pulses every 3 cycles and `phase` advances once per pulse.
- `RST_N` pulled low during EW_GREEN RUN → outputs return immediately to reset values; restart matches the first scenario.
